// File: rtl/fwd_pkg.sv
// Shared constants and types for the RR/EX operand-forwarding and load-use hazard unit.
package fwd_pkg;

  localparam logic [1:0] SEL_ALU    = 2'd0;
  localparam logic [1:0] SEL_ZP9    = 2'd1;
  localparam logic [1:0] SEL_NONE   = 2'd2;
  localparam logic [1:0] SEL_PCPLUS = 2'd3;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } fsm_state_t;

  // Which stage supplied a forwarded operand (debug visibility).
  typedef enum logic [2:0] {
    SRC_NONE  = 3'd0,
    SRC_PC    = 3'd1,
    SRC_EXMEM = 3'd2,
    SRC_MEMWB = 3'd3,
    SRC_HIST  = 3'd4
  } fwd_src_t;

endpackage

// File: rtl/fwd_bypass_unit_if.sv
// Pipeline-side bundle of the forwarding unit: RR/EX sources, EX/Mem and Mem/WB
// write info in; forwarded operands, stall, error and perf counters out.
interface fwd_bypass_unit_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int NUM_RD = 2
) ();
  logic [DATA_W-1:0]        rr_ex_pc;
  logic [NUM_RD*REG_AW-1:0] rr_ex_rs;
  logic [NUM_RD-1:0]        rr_ex_fwd_en;
  logic                     ex_mem_regwrite;
  logic                     ex_mem_is_load;
  logic [REG_AW-1:0]        ex_mem_rd;
  logic [1:0]               ex_mem_sel;
  logic [DATA_W-1:0]        ex_mem_alu_out;
  logic [DATA_W-1:0]        ex_mem_zp9;
  logic [DATA_W-1:0]        ex_mem_pc_plus;
  logic                     mem_wb_regwrite;
  logic [REG_AW-1:0]        mem_wb_rd;
  logic [DATA_W-1:0]        mem_wb_data;
  logic [NUM_RD-1:0]        fwd_valid;
  logic [NUM_RD*DATA_W-1:0] fwd_data;
  logic                     stall;
  logic                     hazard_err;
  logic [NUM_RD*32-1:0]     perf_fwd_cnt;
  logic [31:0]              perf_stall_cnt;

  modport master (
    output rr_ex_pc, rr_ex_rs, rr_ex_fwd_en,
    output ex_mem_regwrite, ex_mem_is_load, ex_mem_rd, ex_mem_sel,
    output ex_mem_alu_out, ex_mem_zp9, ex_mem_pc_plus,
    output mem_wb_regwrite, mem_wb_rd, mem_wb_data,
    input  fwd_valid, fwd_data, stall, hazard_err, perf_fwd_cnt, perf_stall_cnt
  );

  modport slave (
    input  rr_ex_pc, rr_ex_rs, rr_ex_fwd_en,
    input  ex_mem_regwrite, ex_mem_is_load, ex_mem_rd, ex_mem_sel,
    input  ex_mem_alu_out, ex_mem_zp9, ex_mem_pc_plus,
    input  mem_wb_regwrite, mem_wb_rd, mem_wb_data,
    output fwd_valid, fwd_data, stall, hazard_err, perf_fwd_cnt, perf_stall_cnt
  );
endinterface

// File: rtl/fwd_hist_buf.sv
// Shift register of retired Mem/WB writes; entry 0 is the youngest.
module fwd_hist_buf #(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 3,
  parameter int HIST_DEPTH = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_valid,
  input  logic [REG_AW-1:0]            wr_rd,
  input  logic [DATA_W-1:0]            wr_data,
  output logic [HIST_DEPTH-1:0]        hist_valid,
  output logic [HIST_DEPTH*REG_AW-1:0] hist_rd,
  output logic [HIST_DEPTH*DATA_W-1:0] hist_data
);

  logic              valid_reg [HIST_DEPTH];
  logic [REG_AW-1:0] rd_reg    [HIST_DEPTH];
  logic [DATA_W-1:0] data_reg  [HIST_DEPTH];

  // Shifts every cycle, stall or not, since the downstream stages keep retiring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < HIST_DEPTH; k++) begin
        valid_reg[k] <= 1'b0;
        rd_reg[k]    <= '0;
        data_reg[k]  <= '0;
      end
    end else begin
      valid_reg[0] <= wr_valid;
      rd_reg[0]    <= wr_rd;
      data_reg[0]  <= wr_data;
      for (int k = 1; k < HIST_DEPTH; k++) begin
        valid_reg[k] <= valid_reg[k-1];
        rd_reg[k]    <= rd_reg[k-1];
        data_reg[k]  <= data_reg[k-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < HIST_DEPTH; gi++) begin : g_flat
      assign hist_valid[gi]                    = valid_reg[gi];
      assign hist_rd[gi*REG_AW +: REG_AW]      = rd_reg[gi];
      assign hist_data[gi*DATA_W +: DATA_W]    = data_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/fwd_bypass_unit.sv
// Operand forwarding and load-use stall for the RR/EX boundary.
// Optional FWD_PERF_EN macro enables the forward/stall performance counters.
module fwd_bypass_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 3,
  parameter int NUM_RD     = 2,
  parameter int HIST_DEPTH = 1,
  parameter int PC_REG     = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  fwd_bypass_unit_if.slave bus
);

  localparam logic [REG_AW-1:0] PC_IDX = REG_AW'(PC_REG);

  logic [DATA_W-1:0]            ex_mem_val;
  logic                         ex_mem_fwd_ok;
  logic [HIST_DEPTH-1:0]        hist_valid;
  logic [HIST_DEPTH*REG_AW-1:0] hist_rd;
  logic [HIST_DEPTH*DATA_W-1:0] hist_data;
  fwd_src_t                     port_src [NUM_RD];
  logic [NUM_RD-1:0]            fwd_valid_w;
  logic [NUM_RD*DATA_W-1:0]     fwd_data_w;
  logic [NUM_RD-1:0]            load_hit;
  logic                         hazard;
  fsm_state_t                   state_reg, state_next;
  logic                         stall_w, err_set, hazard_err_reg;

  always_comb begin
    ex_mem_val = '0;
    case (bus.ex_mem_sel)
      SEL_ALU:    ex_mem_val = bus.ex_mem_alu_out;
      SEL_ZP9:    ex_mem_val = bus.ex_mem_zp9;
      SEL_PCPLUS: ex_mem_val = bus.ex_mem_pc_plus;
      default:    ex_mem_val = '0;
    endcase
  end

  // A load's data does not exist yet in EX/Mem, so it can never forward from there.
  assign ex_mem_fwd_ok = bus.ex_mem_regwrite && !bus.ex_mem_is_load && (bus.ex_mem_sel != SEL_NONE);

  fwd_hist_buf #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .HIST_DEPTH(HIST_DEPTH)
  ) u_hist (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(bus.mem_wb_regwrite), .wr_rd(bus.mem_wb_rd), .wr_data(bus.mem_wb_data),
    .hist_valid(hist_valid), .hist_rd(hist_rd), .hist_data(hist_data)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_port
      logic [REG_AW-1:0] rs;
      logic              en;
      logic              hist_hit;
      logic [DATA_W-1:0] hist_val;
      fwd_src_t          src;
      logic [DATA_W-1:0] data;

      assign rs = bus.rr_ex_rs[gi*REG_AW +: REG_AW];
      assign en = bus.rr_ex_fwd_en[gi];

      always_comb begin
        hist_hit = 1'b0;
        hist_val = '0;
        // Scan oldest to youngest so the youngest matching entry is the one kept.
        for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
          if (hist_valid[k] && (hist_rd[k*REG_AW +: REG_AW] == rs)) begin
            hist_hit = 1'b1;
            hist_val = hist_data[k*DATA_W +: DATA_W];
          end
        end
        src  = SRC_NONE;
        data = '0;
        if (rs == PC_IDX) begin
          src  = SRC_PC;
          data = bus.rr_ex_pc;
        end else if (en && ex_mem_fwd_ok && (bus.ex_mem_rd == rs)) begin
          src  = SRC_EXMEM;
          data = ex_mem_val;
        end else if (en && bus.mem_wb_regwrite && (bus.mem_wb_rd == rs)) begin
          src  = SRC_MEMWB;
          data = bus.mem_wb_data;
        end else if (en && hist_hit) begin
          src  = SRC_HIST;
          data = hist_val;
        end
      end

      assign port_src[gi]                    = src;
      assign fwd_valid_w[gi]                 = (src != SRC_NONE);
      assign fwd_data_w[gi*DATA_W +: DATA_W] = data;
      assign load_hit[gi] = en && (rs != PC_IDX) && bus.ex_mem_regwrite &&
                            bus.ex_mem_is_load && (bus.ex_mem_rd == rs);
    end
  endgenerate

  assign hazard = |load_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= RUN;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (hazard) state_next = STALL;
      STALL:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // A hazard still visible in STALL means upstream ignored the bubble request.
  always_comb begin
    stall_w = 1'b0;
    err_set = 1'b0;
    case (state_reg)
      RUN:     stall_w = hazard;
      STALL:   err_set = hazard;
      default: stall_w = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       hazard_err_reg <= 1'b0;
    else if (err_set) hazard_err_reg <= 1'b1;
  end

  assign bus.fwd_valid  = fwd_valid_w;
  assign bus.fwd_data   = fwd_data_w;
  assign bus.stall      = stall_w & rst_n;
  assign bus.hazard_err = hazard_err_reg;

`ifdef FWD_PERF_EN
  logic [31:0] stall_cnt_reg;

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_perf
      logic [31:0] fwd_cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          fwd_cnt_reg <= '0;
        else if (port_src[gi] != SRC_NONE && port_src[gi] != SRC_PC)
          fwd_cnt_reg <= fwd_cnt_reg + 32'd1;
      end
      assign bus.perf_fwd_cnt[gi*32 +: 32] = fwd_cnt_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       stall_cnt_reg <= '0;
    else if (stall_w) stall_cnt_reg <= stall_cnt_reg + 32'd1;
  end

  assign bus.perf_stall_cnt = stall_cnt_reg;
`else
  assign bus.perf_fwd_cnt   = '0;
  assign bus.perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_bypass_unit.sv
// Self-checking bench for fwd_bypass_unit: directed cases with literal expectations,
// then randomized traffic compared every cycle against a rule-level model.
module tb_fwd_bypass_unit;
  localparam int DW  = 16;
  localparam int AW  = 3;
  localparam int NR  = 2;
  localparam int HD  = 2;
  localparam int PCR = 7;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fwd_bypass_unit_if #(.DATA_W(DW), .REG_AW(AW), .NUM_RD(NR)) bus ();

  fwd_bypass_unit #(
    .DATA_W(DW), .REG_AW(AW), .NUM_RD(NR), .HIST_DEPTH(HD), .PC_REG(PCR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: last HD retired writes (index 0 youngest), stall memory, sticky error, counters.
  logic          m_hv   [HD] = '{default: 1'b0};
  logic [AW-1:0] m_hrd  [HD] = '{default: '0};
  logic [DW-1:0] m_hd   [HD] = '{default: '0};
  logic          m_prev_stall = 1'b0;
  logic          m_err        = 1'b0;
  logic [31:0]   m_fcnt [NR]  = '{default: '0};
  logic [31:0]   m_scnt       = '0;

  // Literal expectations for directed steps.
  logic        lit_on = 1'b0;
  string       lit_name = "";
  int          lit_port = 0;
  logic        lit_valid = 1'b0;
  logic [15:0] lit_data = '0;
  logic        lit_stall = 1'b0;
  logic        lit_err = 1'b0;
  logic        lit_cnt_on = 1'b0;
  logic [31:0] lit_cnt = '0;

  function automatic logic [AW-1:0] rs_of(int i);
    logic [NR*AW-1:0] v;
    v = bus.rr_ex_rs;
    return v[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] exmem_value();
    case (bus.ex_mem_sel)
      2'd0:    return bus.ex_mem_alu_out;
      2'd1:    return bus.ex_mem_zp9;
      2'd3:    return bus.ex_mem_pc_plus;
      default: return '0;
    endcase
  endfunction

  // rule: 0 none, 1 PC, 2 EX/Mem, 3 Mem/WB, 4 history
  function automatic int exp_rule(int i, output logic [DW-1:0] d);
    logic [AW-1:0] r;
    logic          en;
    r  = rs_of(i);
    en = bus.rr_ex_fwd_en[i];
    d  = '0;
    if (int'(r) == PCR) begin
      d = bus.rr_ex_pc; return 1;
    end
    if (!en) return 0;
    if (bus.ex_mem_regwrite && !bus.ex_mem_is_load && bus.ex_mem_sel != 2'd2 && bus.ex_mem_rd == r) begin
      d = exmem_value(); return 2;
    end
    if (bus.mem_wb_regwrite && bus.mem_wb_rd == r) begin
      d = bus.mem_wb_data; return 3;
    end
    for (int k = 0; k < HD; k++) begin
      if (m_hv[k] && m_hrd[k] == r) begin
        d = m_hd[k]; return 4;
      end
    end
    return 0;
  endfunction

  function automatic logic exp_hazard();
    logic h;
    h = 1'b0;
    for (int i = 0; i < NR; i++)
      if (bus.rr_ex_fwd_en[i] && int'(rs_of(i)) != PCR && bus.ex_mem_regwrite &&
          bus.ex_mem_is_load && bus.ex_mem_rd == rs_of(i))
        h = 1'b1;
    return h;
  endfunction

  function automatic logic exp_stall();
    return rst_n && exp_hazard() && !m_prev_stall;
  endfunction

  function automatic logic fwd_counts(int i);
    logic [DW-1:0] d;
    return exp_rule(i, d) >= 2;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < HD; k++) begin
        m_hv[k] <= 1'b0; m_hrd[k] <= '0; m_hd[k] <= '0;
      end
      m_prev_stall <= 1'b0;
      m_err        <= 1'b0;
      for (int i = 0; i < NR; i++) m_fcnt[i] <= '0;
      m_scnt       <= '0;
    end else begin
      m_hv[0]  <= bus.mem_wb_regwrite;
      m_hrd[0] <= bus.mem_wb_rd;
      m_hd[0]  <= bus.mem_wb_data;
      for (int k = 1; k < HD; k++) begin
        m_hv[k] <= m_hv[k-1]; m_hrd[k] <= m_hrd[k-1]; m_hd[k] <= m_hd[k-1];
      end
      m_prev_stall <= exp_stall();
      if (m_prev_stall && exp_hazard()) m_err <= 1'b1;
      for (int i = 0; i < NR; i++)
        if (fwd_counts(i)) m_fcnt[i] <= m_fcnt[i] + 32'd1;
      if (exp_stall()) m_scnt <= m_scnt + 32'd1;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Single compare process: model every cycle, plus literal expectations on directed steps.
  always @(negedge clk) begin
    logic [DW-1:0] ed;
    logic [DW-1:0] ad;
    logic [31:0]   ec;
    for (int i = 0; i < NR; i++) begin
      int r;
      r  = exp_rule(i, ed);
      ad = bus.fwd_data[i*DW +: DW];
      chk($sformatf("valid%0d", i), 32'(bus.fwd_valid[i]), 32'(r != 0));
      chk($sformatf("data%0d", i), 32'(ad), 32'(ed));
`ifdef FWD_PERF_EN
      ec = m_fcnt[i];
`else
      ec = '0;
`endif
      chk($sformatf("fwdcnt%0d", i), bus.perf_fwd_cnt[i*32 +: 32], ec);
    end
    chk("stall", 32'(bus.stall), 32'(exp_stall()));
    chk("hazard_err", 32'(bus.hazard_err), 32'(m_err));
`ifdef FWD_PERF_EN
    ec = m_scnt;
`else
    ec = '0;
`endif
    chk("stallcnt", bus.perf_stall_cnt, ec);
    if (lit_on) begin
      chk({lit_name, ".valid"}, 32'(bus.fwd_valid[lit_port]), 32'(lit_valid));
      chk({lit_name, ".data"}, 32'(bus.fwd_data[lit_port*DW +: DW]), 32'(lit_data));
      chk({lit_name, ".stall"}, 32'(bus.stall), 32'(lit_stall));
      chk({lit_name, ".err"}, 32'(bus.hazard_err), 32'(lit_err));
`ifdef FWD_PERF_EN
      if (lit_cnt_on) chk({lit_name, ".cnt"}, bus.perf_fwd_cnt[lit_port*32 +: 32], lit_cnt);
`endif
    end
  end

  task automatic idle();
    bus.rr_ex_pc = '0; bus.rr_ex_rs = '0; bus.rr_ex_fwd_en = '0;
    bus.ex_mem_regwrite = 1'b0; bus.ex_mem_is_load = 1'b0; bus.ex_mem_rd = '0;
    bus.ex_mem_sel = 2'd2; bus.ex_mem_alu_out = '0; bus.ex_mem_zp9 = '0; bus.ex_mem_pc_plus = '0;
    bus.mem_wb_regwrite = 1'b0; bus.mem_wb_rd = '0; bus.mem_wb_data = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    lit_on = 1'b0;
    lit_cnt_on = 1'b0;
    idle();
  endtask

  task automatic lit(string nm, int port, logic v, logic [15:0] d, logic st, logic er);
    lit_name = nm; lit_port = port; lit_valid = v; lit_data = d;
    lit_stall = st; lit_err = er; lit_on = 1'b1;
    $display("STEP %s port=%0d", nm, port);
  endtask

  task automatic set_load(logic [AW-1:0] rd);
    bus.ex_mem_regwrite = 1'b1; bus.ex_mem_is_load = 1'b1; bus.ex_mem_rd = rd; bus.ex_mem_sel = 2'd0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    lit("reset", 0, 1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    next_cycle();
    bus.rr_ex_rs = 6'o07; bus.rr_ex_pc = 16'h0040;
    lit("pc_alias", 0, 1'b1, 16'h0040, 1'b0, 1'b0);

    next_cycle();
    bus.ex_mem_regwrite = 1'b1; bus.ex_mem_rd = 3'd3; bus.ex_mem_sel = 2'd1; bus.ex_mem_zp9 = 16'h1234;
    bus.mem_wb_regwrite = 1'b1; bus.mem_wb_rd = 3'd3; bus.mem_wb_data = 16'h5555;
    bus.rr_ex_rs = 6'o30; bus.rr_ex_fwd_en = 2'b10;
    lit("exmem_over_memwb", 1, 1'b1, 16'h1234, 1'b0, 1'b0);

    next_cycle();
    bus.mem_wb_regwrite = 1'b1; bus.mem_wb_rd = 3'd2; bus.mem_wb_data = 16'hBEEF;
    next_cycle();
    bus.rr_ex_rs = 6'o02; bus.rr_ex_fwd_en = 2'b01;
    lit("hist0", 0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    next_cycle();
    bus.rr_ex_rs = 6'o02; bus.rr_ex_fwd_en = 2'b01;
    lit("hist1", 0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    next_cycle();
    bus.rr_ex_rs = 6'o02; bus.rr_ex_fwd_en = 2'b01;
    lit("hist_aged_out", 0, 1'b0, 16'h0000, 1'b0, 1'b0);

    next_cycle();
    set_load(3'd4); bus.rr_ex_rs = 6'o40; bus.rr_ex_fwd_en = 2'b10;
    lit("load_use_stall", 1, 1'b0, 16'h0000, 1'b1, 1'b0);
    next_cycle();
    bus.mem_wb_regwrite = 1'b1; bus.mem_wb_rd = 3'd4; bus.mem_wb_data = 16'h00AA;
    bus.rr_ex_rs = 6'o40; bus.rr_ex_fwd_en = 2'b10;
    lit("load_resolved", 1, 1'b1, 16'h00AA, 1'b0, 1'b0);

    next_cycle();
    set_load(3'd5); bus.rr_ex_rs = 6'o05; bus.rr_ex_fwd_en = 2'b01;
    lit("held_hazard1", 0, 1'b0, 16'h0000, 1'b1, 1'b0);
    next_cycle();
    set_load(3'd5); bus.rr_ex_rs = 6'o05; bus.rr_ex_fwd_en = 2'b01;
    lit("held_hazard2", 0, 1'b0, 16'h0000, 1'b0, 1'b0);
    next_cycle();
    lit("err_sticky1", 0, 1'b0, 16'h0000, 1'b0, 1'b1);
    next_cycle();
    lit("err_sticky2", 0, 1'b0, 16'h0000, 1'b0, 1'b1);
    next_cycle();
    rst_n = 1'b0;
    lit("err_cleared", 0, 1'b0, 16'h0000, 1'b0, 1'b0);
    next_cycle();
    rst_n = 1'b1;

    next_cycle();
    set_load(3'd4); bus.rr_ex_rs = 6'o04; bus.rr_ex_fwd_en = 2'b01;
    bus.mem_wb_regwrite = 1'b1; bus.mem_wb_rd = 3'd5; bus.mem_wb_data = 16'h0555;
    lit("stall_before_reset", 0, 1'b0, 16'h0000, 1'b1, 1'b0);
    next_cycle();
    rst_n = 1'b0;
    set_load(3'd4); bus.rr_ex_rs = 6'o45; bus.rr_ex_fwd_en = 2'b11;
    lit("reset_in_stall", 0, 1'b0, 16'h0000, 1'b0, 1'b0);
    lit_cnt_on = 1'b1; lit_cnt = 32'd0;
    next_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      bus.mem_wb_regwrite = 1'b1; bus.mem_wb_rd = 3'd1; bus.mem_wb_data = 16'h0100 + 16'(k);
      bus.rr_ex_rs = 6'o01; bus.rr_ex_fwd_en = 2'b01;
      lit($sformatf("memwb_fwd%0d", k), 0, 1'b1, 16'h0100 + 16'(k), 1'b0, 1'b0);
    end
    next_cycle();
    lit("count_five", 0, 1'b0, 16'h0000, 1'b0, 1'b0);
    lit_cnt_on = 1'b1; lit_cnt = 32'd5;

    for (int c = 0; c < 800; c++) begin
      next_cycle();
      rst_n = ($urandom_range(0, 59) != 0);
      bus.rr_ex_pc        = 16'($urandom);
      bus.rr_ex_rs        = 6'($urandom);
      bus.rr_ex_fwd_en    = 2'($urandom);
      bus.ex_mem_regwrite = ($urandom_range(0, 3) != 0);
      bus.ex_mem_is_load  = ($urandom_range(0, 3) == 0);
      bus.ex_mem_rd       = 3'($urandom);
      bus.ex_mem_sel      = 2'($urandom);
      bus.ex_mem_alu_out  = 16'($urandom);
      bus.ex_mem_zp9      = 16'($urandom);
      bus.ex_mem_pc_plus  = 16'($urandom);
      bus.mem_wb_regwrite = ($urandom_range(0, 3) != 0);
      bus.mem_wb_rd       = 3'($urandom);
      bus.mem_wb_data     = 16'($urandom);
      $display("TXN %0d rst_n=%0b rs=%o en=%b exm=%0b/%0b rd%0d sel%0d mwb=%0b rd%0d",
               c, rst_n, bus.rr_ex_rs, bus.rr_ex_fwd_en, bus.ex_mem_regwrite,
               bus.ex_mem_is_load, bus.ex_mem_rd, bus.ex_mem_sel, bus.mem_wb_regwrite, bus.mem_wb_rd);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
